fifo_storage: RTL and testbench

Data-path companion to the FIFO address generator. Holds the FIFO memory array, performs the writes and reads that the address generator grants, and delivers read data to the downstream consumer through a two-entry skid buffer with a valid/ready handshake. It sits directly downstream of the address generator, consuming its write/read grants and addresses, and decouples the consumer's backpressure from the grant timing.

---
 rtl/fifo_storage_pkg.sv | 15 +
 rtl/fifo_skid_buf.sv | 105 ++++++++++
 rtl/fifo_storage.sv | 84 ++++++++
 tb/tb_fifo_storage.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_storage_pkg.sv
// Shared definitions for the FIFO storage slice: default geometry and skid buffer states.
// The top module honours the optional FIFO_WR_BYPASS_EN build macro.
package fifo_storage_pkg;

    localparam int FIFO_ADDR_W = 32;
    localparam int FIFO_DEEP   = 16;
    localparam int FIFO_DATA_W = 32;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_e;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry output skid buffer with valid/ready handshake and sticky overrun flag.
// Outputs are driven straight from registers; dout_ready only steers next state.
module fifo_skid_buf
    import fifo_storage_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              dout_ready,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              overrun
);

    skid_state_e       state_r, state_nxt_s;
    logic [DATA_W-1:0] head_r, head_nxt_s;
    logic [DATA_W-1:0] tail_r, tail_nxt_s;
    logic              valid_r, valid_nxt_s;
    logic              overrun_r, overrun_nxt_s;
    logic              pop_s;

    assign pop_s = valid_r & dout_ready;

    // Buffer state, entries and flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= SKID_EMPTY;
            head_r    <= {DATA_W{1'b0}};
            tail_r    <= {DATA_W{1'b0}};
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            head_r    <= head_nxt_s;
            tail_r    <= tail_nxt_s;
            valid_r   <= valid_nxt_s;
            overrun_r <= overrun_nxt_s;
        end
    end

    // Next-state logic: flush wins over any same-cycle push or pop
    always_comb begin
        state_nxt_s   = state_r;
        head_nxt_s    = head_r;
        tail_nxt_s    = tail_r;
        valid_nxt_s   = valid_r;
        overrun_nxt_s = overrun_r;
        if (flush) begin
            state_nxt_s   = SKID_EMPTY;
            valid_nxt_s   = 1'b0;
            overrun_nxt_s = 1'b0;
        end else begin
            case (state_r)
                SKID_EMPTY: begin
                    if (push) begin
                        head_nxt_s  = push_data;
                        valid_nxt_s = 1'b1;
                        state_nxt_s = SKID_ONE;
                    end else begin
                        state_nxt_s = SKID_EMPTY;
                    end
                end
                SKID_ONE: begin
                    if (push && pop_s) begin
                        head_nxt_s  = push_data;
                    end else if (push) begin
                        tail_nxt_s  = push_data;
                        state_nxt_s = SKID_TWO;
                    end else if (pop_s) begin
                        valid_nxt_s = 1'b0;
                        state_nxt_s = SKID_EMPTY;
                    end else begin
                        state_nxt_s = SKID_ONE;
                    end
                end
                SKID_TWO: begin
                    if (push && pop_s) begin
                        head_nxt_s  = tail_r;
                        tail_nxt_s  = push_data;
                    end else if (pop_s) begin
                        head_nxt_s  = tail_r;
                        state_nxt_s = SKID_ONE;
                    end else if (push) begin
                        overrun_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = SKID_TWO;
                    end
                end
                default: begin
                    state_nxt_s = SKID_EMPTY;
                    valid_nxt_s = 1'b0;
                end
            endcase
        end
    end

    assign dout       = head_r;
    assign dout_valid = valid_r;
    assign overrun    = overrun_r;

endmodule

// File: rtl/fifo_storage.sv
// FIFO memory array driven by the address generator's grants, feeding a skid buffer.
// Define FIFO_WR_BYPASS_EN for write-first behaviour on same-address write/read.
module fifo_storage
    import fifo_storage_pkg::*;
#(
    parameter int WIDTH  = FIFO_ADDR_W,
    parameter int DATA_W = FIFO_DATA_W,
    parameter int DEPTH  = FIFO_DEEP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              flush,
    input  logic              we_n,
    input  logic              re_n,
    input  logic [WIDTH-1:0]  wr_addr,
    input  logic [WIDTH-1:0]  rd_addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              overrun
);

    localparam int               AW      = $clog2(DEPTH);
    localparam logic [WIDTH-1:0] DEPTH_L = WIDTH'(DEPTH);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic              wr_en_s;
    logic              rd_in_range_s;
    logic              wr_in_range_s;
    logic              bypass_hit_s;
    logic              flush_s;
    logic              push_s;
    logic [DATA_W-1:0] rd_data_s;

    assign wr_in_range_s = (wr_addr < DEPTH_L);
    assign rd_in_range_s = (rd_addr < DEPTH_L);
    assign wr_en_s       = en & we_n & wr_in_range_s;
    assign flush_s       = en & flush;
    assign push_s        = en & re_n;

`ifdef FIFO_WR_BYPASS_EN
    assign bypass_hit_s = wr_en_s & rd_in_range_s & (wr_addr == rd_addr);
`else
    assign bypass_hit_s = 1'b0;
`endif

    // Memory write port; contents survive reset and flush
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_addr[AW-1:0]] <= din;
        end else begin
            mem_r[wr_addr[AW-1:0]] <= mem_r[wr_addr[AW-1:0]];
        end
    end

    // Read data select: bypass, memory, or zero for out-of-range
    always_comb begin
        rd_data_s = {DATA_W{1'b0}};
        if (bypass_hit_s) begin
            rd_data_s = din;
        end else if (rd_in_range_s) begin
            rd_data_s = mem_r[rd_addr[AW-1:0]];
        end else begin
            rd_data_s = {DATA_W{1'b0}};
        end
    end

    fifo_skid_buf #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush_s),
        .push       (push_s),
        .push_data  (rd_data_s),
        .dout_ready (dout_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .overrun    (overrun)
    );

endmodule

// File: tb/tb_fifo_storage.sv
// Directed self-checking bench for fifo_storage (default geometry: 32-bit addr/data, 16 entries).
module tb_fifo_storage;

    logic        clk;
    logic        rst;
    logic        en;
    logic        flush;
    logic        we_n;
    logic        re_n;
    logic [31:0] wr_addr;
    logic [31:0] rd_addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    fifo_storage dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .flush      (flush),
        .we_n       (we_n),
        .re_n       (re_n),
        .wr_addr    (wr_addr),
        .rd_addr    (rd_addr),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        we_n = 1'b1; wr_addr = a; din = d;
        step();
        we_n = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a);
        re_n = 1'b1; rd_addr = a;
        step();
        re_n = 1'b0;
    endtask

    logic [31:0] same_edge_exp;

    initial begin
        rst = 1'b1; en = 1'b0; flush = 1'b0; we_n = 1'b0; re_n = 1'b0;
        wr_addr = 32'd0; rd_addr = 32'd0; din = 32'd0; dout_ready = 1'b0;
`ifdef FIFO_WR_BYPASS_EN
        same_edge_exp = 32'h0000_BEEF;
`else
        same_edge_exp = 32'h0000_1234;
`endif
        #2;
        chk("rst_valid", {31'd0, dout_valid}, 32'd0);
        chk("rst_dout", dout, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        #1 rst = 1'b0;
        en = 1'b1;

        // basic write then read
        wr(32'd3, 32'hA5A5_0001);
        rd(32'd3);
        chk("rd_valid", {31'd0, dout_valid}, 32'd1);
        chk("rd_dout", dout, 32'hA5A5_0001);
        chk("rd_overrun", {31'd0, overrun}, 32'd0);
        dout_ready = 1'b1;
        step();
        chk("pop_empty", {31'd0, dout_valid}, 32'd0);

        // backpressure and overrun
        dout_ready = 1'b0;
        wr(32'd0, 32'h11);
        wr(32'd1, 32'h22);
        wr(32'd2, 32'h33);
        rd(32'd0);
        chk("bp_first", dout, 32'h11);
        rd(32'd1);
        rd(32'd2);
        chk("bp_head", dout, 32'h11);
        chk("bp_overrun", {31'd0, overrun}, 32'd1);
        dout_ready = 1'b1;
        step();
        chk("bp_second", dout, 32'h22);
        chk("bp_second_v", {31'd0, dout_valid}, 32'd1);
        step();
        chk("bp_drained", {31'd0, dout_valid}, 32'd0);
        chk("bp_sticky", {31'd0, overrun}, 32'd1);

        // flush in TWO with a same-cycle push discarded
        dout_ready = 1'b0;
        rd(32'd0);
        rd(32'd1);
        flush = 1'b1; re_n = 1'b1; rd_addr = 32'd2;
        step();
        flush = 1'b0; re_n = 1'b0;
        chk("flush_valid", {31'd0, dout_valid}, 32'd0);
        chk("flush_overrun", {31'd0, overrun}, 32'd0);
        step();
        chk("flush_no_push", {31'd0, dout_valid}, 32'd0);
        rd(32'd2);
        chk("flush_mem_kept", dout, 32'h33);
        dout_ready = 1'b1;
        step();

        // same-edge write and read
        dout_ready = 1'b0;
        wr(32'd5, 32'h1234);
        we_n = 1'b1; wr_addr = 32'd5; din = 32'hBEEF;
        re_n = 1'b1; rd_addr = 32'd5;
        step();
        we_n = 1'b0; re_n = 1'b0;
        chk("same_edge", dout, same_edge_exp);
        dout_ready = 1'b1;
        step();
        rd(32'd5);
        chk("same_edge_mem", dout, 32'h0000_BEEF);
        step();
        chk("same_edge_pop", {31'd0, dout_valid}, 32'd0);

        // push and pop together in TWO
        dout_ready = 1'b0;
        rd(32'd0);
        rd(32'd1);
        dout_ready = 1'b1;
        rd(32'd2);
        chk("pp_head1", dout, 32'h22);
        rd(32'd3);
        chk("pp_head2", dout, 32'h33);
        chk("pp_no_overrun", {31'd0, overrun}, 32'd0);
        step();
        chk("pp_head3", dout, 32'hA5A5_0001);
        step();
        chk("pp_drained", {31'd0, dout_valid}, 32'd0);

        // enable gating and out-of-range addresses
        en = 1'b0;
        rd(32'd0);
        chk("en_off_push", {31'd0, dout_valid}, 32'd0);
        en = 1'b1;
        dout_ready = 1'b0;
        rd(32'd16);
        chk("oor_rd_valid", {31'd0, dout_valid}, 32'd1);
        chk("oor_rd_data", dout, 32'd0);
        dout_ready = 1'b1;
        wr(32'd19, 32'hDEAD_DEAD);
        rd(32'd3);
        chk("oor_wr_ignored", dout, 32'hA5A5_0001);
        step();

        // asynchronous reset between edges
        dout_ready = 1'b0;
        rd(32'd0);
        rd(32'd1);
        rd(32'd2);
        chk("pre_rst_overrun", {31'd0, overrun}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_valid", {31'd0, dout_valid}, 32'd0);
        chk("async_overrun", {31'd0, overrun}, 32'd0);
        chk("async_dout", dout, 32'd0);
        #1 rst = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
